sel_scan_scheduler: RTL and testbench
=====================================

// Module: sel_scan_scheduler
// PURPOSE
// Sequences the test-structure sequencer across a range of SEL values without per-shot SPI traffic.
// - For each SEL value it issues a fixed number of sequencer runs.
// - Each run is paced by an internal gap counter or by an external trigger.
// - Sits between the SPI command decoder (configuration, start/abort) and the sequencer's run/ready handshake.
// PARAMETERS
// SEL_W   4   width of SEL field / sequencer SEL_input
// REPS_W  10  width of repetitions-per-SEL count
// GAP_W   16  width of inter-run gap counter (clk cycles)
// ACK_TO  8   max cycles from seq_run until seq_ready must fall
// PORTS
// clk          in   1       system clock (PLL c0)
// res_n        in   1       asynchronous active-low reset
// start        in   1       1-cycle pulse: latch config, begin scan
// abort        in   1       1-cycle pulse: stop scan immediately
// sel_first    in   SEL_W   first SEL value of scan
// sel_last     in   SEL_W   last SEL value of scan (inclusive)
// reps_per_sel in   REPS_W  runs per SEL value; 0 treated as 1
// gap_cycles   in   GAP_W   idle cycles before each run (internal mode)
// ext_mode     in   1       1: pace runs by ext_trigger, 0: by gap_cycles
// ext_trigger  in   1       asynchronous trigger (LEMO/DIO)
// seq_ready    in   1       sequencer ready_flag
// seq_run      out  1       1-cycle run_sequencer pulse
// seq_sel      out  SEL_W   SEL_input to sequencer
// cur_rep      out  REPS_W  index of current run within SEL value
// busy         out  1       scan in progress
// done         out  1       1-cycle pulse, scan completed normally
// err          out  1       sticky: handshake timeout; cleared by next accepted start
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, latched config 0.
// - Config is latched on the accepted start; later input changes have no effect until the next start.
// - States and transitions:
//   - IDLE: start accepted here only → ARM. busy=1 from the next cycle.
//     - abort in the same cycle as start → start ignored.
//     - start while busy → ignored.
//   - ARM: seq_sel<=sel_first, cur_rep<=0, gap counter loaded → WAIT.
//   - WAIT, internal mode: count gap_cycles cycles, then → FIRE. gap_cycles=0 → FIRE next cycle.
//   - WAIT, ext mode:
//     - ext_trigger passes a 2-FF synchronizer plus rising-edge detect.
//     - A detected edge → FIRE.
//     - Edges outside WAIT are dropped, not queued.
//   - FIRE: seq_run=1 for exactly one cycle, only if seq_ready=1; otherwise hold in FIRE → WAIT_ACK.
//   - WAIT_ACK: wait for seq_ready=0.
//     - Exceeding ACK_TO cycles → err=1, busy=0, → IDLE; no done.
//   - WAIT_RDY: wait for seq_ready=1 → NEXT.
//   - NEXT:
//     - If cur_rep < reps-1: cur_rep+1, reload gap → WAIT.
//     - Else if seq_sel==sel_last: done=1 for 1 cycle, busy=0 → IDLE.
//     - Else: seq_sel+1 modulo 2^SEL_W, cur_rep=0, reload gap → WAIT.
// - seq_sel is constant from FIRE until NEXT (stable during the whole run).
// - Wrap-around: sel_first > sel_last scans upward through 2^SEL_W-1 to 0 and on to sel_last.
// - sel_first==sel_last: single SEL value.
// - abort in any non-IDLE state: next cycle → IDLE, busy=0, seq_run=0, no done.
//   - err unchanged.
//   - seq_sel and cur_rep hold their last values.
// - Total runs per scan = (#SEL values)*max(reps,1); all counters are unsigned, no saturation needed.
// TESTING
// 1. Internal mode: sel 2..4, reps=3, gap=5, ideal sequencer (ready low 10 cycles per run).
//    -> 9 seq_run pulses, seq_sel 2,2,2,3,3,3,4,4,4.
//    -> Each run at least 5 cycles after previous ready rise; single done pulse; busy drops with done.
// 2. Wrap: sel_first=14, sel_last=1, reps=1, gap=0 -> seq_sel 14,15,0,1, 4 runs, done.
// 3. Ext mode: reps=2 on sel=7, 3 trigger edges, 2nd edge arriving mid-run.
//    -> Mid-run edge dropped; second run fires only on the 3rd edge; then done.
// 4. Timeout: seq_ready held high after seq_run.
//    -> err=1 at cycle ACK_TO after seq_run; busy=0; no done.
//    -> Next start clears err.
// 5. Abort during WAIT_RDY of run 2 -> busy=0 next cycle, no further seq_run, no done.
//    Start+abort in the same cycle in IDLE -> busy stays 0.
// 6. reps_per_sel=0, sel 5..5 -> exactly one seq_run, then done.
//    Reset asserted mid-scan -> all outputs 0 immediately.

Source files
------------

// File: rtl/sel_scan_scheduler.sv
// Scan scheduler: steps the test-structure sequencer through a range of SEL values,
// issuing a fixed number of runs per value, paced by a gap counter or an external trigger.
module sel_scan_scheduler #(
    parameter int SEL_W  = 4,
    parameter int REPS_W = 10,
    parameter int GAP_W  = 16,
    parameter int ACK_TO = 8
) (
    input  logic              clk,
    input  logic              res_n,
    input  logic              start,
    input  logic              abort,
    input  logic [SEL_W-1:0]  sel_first,
    input  logic [SEL_W-1:0]  sel_last,
    input  logic [REPS_W-1:0] reps_per_sel,
    input  logic [GAP_W-1:0]  gap_cycles,
    input  logic              ext_mode,
    input  logic              ext_trigger,
    input  logic              seq_ready,
    output logic              seq_run,
    output logic [SEL_W-1:0]  seq_sel,
    output logic [REPS_W-1:0] cur_rep,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2:0]        state_dbg
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ARM      = 3'd1;
    localparam logic [2:0] S_WAIT     = 3'd2;
    localparam logic [2:0] S_FIRE     = 3'd3;
    localparam logic [2:0] S_WAIT_ACK = 3'd4;
    localparam logic [2:0] S_WAIT_RDY = 3'd5;
    localparam logic [2:0] S_NEXT     = 3'd6;

    localparam int ACK_W = $clog2(ACK_TO + 1);
    localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TO - 1);

    logic [2:0]        state;
    logic [SEL_W-1:0]  sel_first_q;
    logic [SEL_W-1:0]  sel_last_q;
    logic [REPS_W-1:0] reps_q;
    logic [GAP_W-1:0]  gap_q;
    logic              ext_q;
    logic [GAP_W-1:0]  gap_cnt;
    logic [ACK_W-1:0]  ack_cnt;
    logic [1:0]        ext_sync;
    logic              ext_prev;
    logic              trig_edge;
    logic [REPS_W-1:0] last_rep;

    assign state_dbg = state;
    assign trig_edge = ext_sync[1] & ~ext_prev;
    // A repetition count of zero behaves like one.
    assign last_rep  = (reps_q == '0) ? '0 : reps_q - REPS_W'(1);

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            ext_sync <= '0;
            ext_prev <= 1'b0;
        end else begin
            ext_sync <= {ext_sync[0], ext_trigger};
            ext_prev <= ext_sync[1];
        end
    end

    // Handshake: seq_run is a one-cycle request issued only while seq_ready=1; the
    // sequencer accepts by dropping seq_ready and signals completion by raising it again.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state       <= S_IDLE;
            sel_first_q <= '0;
            sel_last_q  <= '0;
            reps_q      <= '0;
            gap_q       <= '0;
            ext_q       <= 1'b0;
            gap_cnt     <= '0;
            ack_cnt     <= '0;
            seq_run     <= 1'b0;
            seq_sel     <= '0;
            cur_rep     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            seq_run <= 1'b0;
            done    <= 1'b0;
            if (abort && state != S_IDLE) begin
                state <= S_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            sel_first_q <= sel_first;
                            sel_last_q  <= sel_last;
                            reps_q      <= reps_per_sel;
                            gap_q       <= gap_cycles;
                            ext_q       <= ext_mode;
                            err         <= 1'b0;
                            busy        <= 1'b1;
                            state       <= S_ARM;
                        end
                    end
                    S_ARM: begin
                        seq_sel <= sel_first_q;
                        cur_rep <= '0;
                        gap_cnt <= gap_q;
                        state   <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (ext_q) begin
                            if (trig_edge) state <= S_FIRE;
                        end else if (gap_cnt == '0) begin
                            state <= S_FIRE;
                        end else begin
                            gap_cnt <= gap_cnt - GAP_W'(1);
                        end
                    end
                    S_FIRE: begin
                        if (seq_ready) begin
                            seq_run <= 1'b1;
                            ack_cnt <= '0;
                            state   <= S_WAIT_ACK;
                        end
                    end
                    S_WAIT_ACK: begin
                        if (!seq_ready) begin
                            state <= S_WAIT_RDY;
                        end else if (ack_cnt == ACK_LAST) begin
                            err   <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            ack_cnt <= ack_cnt + ACK_W'(1);
                        end
                    end
                    S_WAIT_RDY: begin
                        if (seq_ready) state <= S_NEXT;
                    end
                    S_NEXT: begin
                        if (cur_rep != last_rep) begin
                            cur_rep <= cur_rep + REPS_W'(1);
                            gap_cnt <= gap_q;
                            state   <= S_WAIT;
                        end else if (seq_sel == sel_last_q) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            // Wraps through 2^SEL_W-1 to 0 when sel_first > sel_last.
                            seq_sel <= seq_sel + SEL_W'(1);
                            cur_rep <= '0;
                            gap_cnt <= gap_q;
                            state   <= S_WAIT;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sel_scan_scheduler.sv
// Bench for sel_scan_scheduler: sequencer model, run monitor and a scan-order reference
// model built from the SEL range and repetition count.
module tb_sel_scan_scheduler;

  localparam int SEL_W  = 4;
  localparam int REPS_W = 10;
  localparam int GAP_W  = 16;
  localparam int ACK_TO = 8;
  localparam int RW     = SEL_W + REPS_W;
  localparam int NSEL   = 1 << SEL_W;

  logic              clk = 1'b0;
  logic              res_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [SEL_W-1:0]  sel_first = '0;
  logic [SEL_W-1:0]  sel_last = '0;
  logic [REPS_W-1:0] reps_per_sel = '0;
  logic [GAP_W-1:0]  gap_cycles = '0;
  logic              ext_mode = 1'b0;
  logic              ext_trigger = 1'b0;
  logic              seq_ready = 1'b1;
  logic              seq_run;
  logic [SEL_W-1:0]  seq_sel;
  logic [REPS_W-1:0] cur_rep;
  logic              busy;
  logic              done;
  logic              err;
  logic [2:0]        state_dbg;

  int checks = 0;
  int errors = 0;

  sel_scan_scheduler #(
    .SEL_W(SEL_W), .REPS_W(REPS_W), .GAP_W(GAP_W), .ACK_TO(ACK_TO)
  ) dut (
    .clk(clk), .res_n(res_n), .start(start), .abort(abort),
    .sel_first(sel_first), .sel_last(sel_last), .reps_per_sel(reps_per_sel),
    .gap_cycles(gap_cycles), .ext_mode(ext_mode), .ext_trigger(ext_trigger),
    .seq_ready(seq_ready), .seq_run(seq_run), .seq_sel(seq_sel), .cur_rep(cur_rep),
    .busy(busy), .done(done), .err(err), .state_dbg(state_dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // sequencer model: accepts a run by dropping ready, holds it low 10 cycles
  bit seq_stuck = 1'b0;
  int seq_low_cnt = 0;
  int last_rise_cyc = 0;
  always @(negedge clk) begin
    if (seq_run && !seq_stuck) begin
      seq_ready = 1'b0;
      seq_low_cnt = 10;
    end else if (seq_low_cnt > 0) begin
      seq_low_cnt = seq_low_cnt - 1;
      if (seq_low_cnt == 0) begin
        seq_ready = 1'b1;
        last_rise_cyc = cyc;
      end
    end
  end

  // monitor
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] got_q[$];
  int run_cyc_q[$];
  int gap_cyc_q[$];
  int done_cnt = 0;
  int done_busy_bad = 0;
  int err_rise_cyc = 0;
  logic prev_busy = 1'b0;
  logic prev_err = 1'b0;
  always @(negedge clk) begin
    if (seq_run) begin
      got_q.push_back({seq_sel, cur_rep});
      run_cyc_q.push_back(cyc);
      gap_cyc_q.push_back(cyc - last_rise_cyc);
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      if (busy || !prev_busy) done_busy_bad = done_busy_bad + 1;
    end
    if (err && !prev_err) err_rise_cyc = cyc;
    prev_busy = busy;
    prev_err = err;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // reference: every SEL value from first up to last (mod 2^SEL_W), max(reps,1) runs each
  task automatic build_exp(input int first, input int last, input int reps);
    int n_sel;
    int n_rep;
    n_sel = ((last - first + NSEL) % NSEL) + 1;
    n_rep = (reps == 0) ? 1 : reps;
    exp_q.delete();
    for (int i = 0; i < n_sel; i++)
      for (int r = 0; r < n_rep; r++)
        exp_q.push_back({SEL_W'((first + i) % NSEL), REPS_W'(r)});
  endtask

  // driver: start a scan, scramble config afterwards, wait for busy to drop
  task automatic do_scan(input int first, input int last, input int reps, input int gap,
                         output bit to, output logic b0, output logic e0);
    int n;
    got_q.delete();
    run_cyc_q.delete();
    gap_cyc_q.delete();
    sel_first = SEL_W'(first);
    sel_last = SEL_W'(last);
    reps_per_sel = REPS_W'(reps);
    gap_cycles = GAP_W'(gap);
    ext_mode = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    b0 = busy;
    e0 = err;
    sel_first = SEL_W'($urandom_range(0, NSEL - 1));
    sel_last = SEL_W'($urandom_range(0, NSEL - 1));
    reps_per_sel = REPS_W'($urandom_range(0, 7));
    gap_cycles = GAP_W'($urandom_range(0, 50));
    ext_mode = 1'($urandom_range(0, 1));
    n = 0;
    while (busy && n < 3000) begin
      step();
      n++;
    end
    to = (n >= 3000);
    step();
    step();
  endtask

  task automatic test_reset();
    checks++; if (seq_run !== 1'b0) begin errors++; $display("FAIL reset_seq_run: got %0h expected 0", seq_run); end
    checks++; if (seq_sel !== '0) begin errors++; $display("FAIL reset_seq_sel: got %0h expected 0", seq_sel); end
    checks++; if (cur_rep !== '0) begin errors++; $display("FAIL reset_cur_rep: got %0h expected 0", cur_rep); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0h expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0h expected 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0h expected 0", err); end
  endtask

  task automatic test_internal();
    bit to;
    logic b0, e0;
    int d0;
    d0 = done_cnt;
    build_exp(2, 4, 3);
    do_scan(2, 4, 3, 5, to, b0, e0);
    checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL int_busy_after_start: got %0h expected 1", b0); end
    checks++; if (to) begin errors++; $display("FAIL int_timeout: got busy stuck expected scan end"); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL int_run_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL int_run%0d: got %0h expected %0h", i, got_q[i], exp_q[i]); end
    end
    for (int i = 1; i < gap_cyc_q.size(); i++) begin
      checks++; if (gap_cyc_q[i] < 5) begin errors++; $display("FAIL int_gap%0d: got %0d expected >=5", i, gap_cyc_q[i]); end
    end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL int_done_count: got %0d expected 1", done_cnt - d0); end
    checks++; if (done_busy_bad != 0) begin errors++; $display("FAIL int_done_busy: got %0d expected 0", done_busy_bad); end
  endtask

  task automatic test_wrap();
    bit to;
    logic b0, e0;
    int d0;
    d0 = done_cnt;
    build_exp(14, 1, 1);
    do_scan(14, 1, 1, 0, to, b0, e0);
    checks++; if (got_q.size() != 4) begin errors++; $display("FAIL wrap_run_count: got %0d expected 4", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL wrap_run%0d: got %0h expected %0h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (done_cnt - d0 != 1 || to) begin errors++; $display("FAIL wrap_done: got %0d expected 1", done_cnt - d0); end
  endtask

  task automatic pulse_trigger(input int hi, input int lo);
    ext_trigger = 1'b1;
    repeat (hi) step();
    ext_trigger = 1'b0;
    repeat (lo) step();
  endtask

  task automatic test_ext();
    int d0;
    int n;
    d0 = done_cnt;
    got_q.delete();
    build_exp(7, 7, 2);
    sel_first = 4'd7;
    sel_last = 4'd7;
    reps_per_sel = 10'd2;
    gap_cycles = '0;
    ext_mode = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    ext_mode = 1'b0;
    repeat (6) step();
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL ext_no_free_run: got %0d expected 0", got_q.size()); end
    pulse_trigger(3, 0);
    n = 0;
    while (got_q.size() < 1 && n < 20) begin step(); n++; end
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL ext_first_run: got %0d expected 1", got_q.size()); end
    pulse_trigger(2, 2);
    repeat (30) step();
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL ext_midrun_drop: got %0d expected 1", got_q.size()); end
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL ext_early_done: got %0d expected %0d", done_cnt, d0); end
    pulse_trigger(3, 0);
    n = 0;
    while (busy && n < 40) begin step(); n++; end
    step();
    checks++; if (got_q.size() != 2) begin errors++; $display("FAIL ext_run_count: got %0d expected 2", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ext_run%0d: got %0h expected %0h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL ext_done: got %0d expected 1", done_cnt - d0); end
  endtask

  task automatic test_timeout();
    bit to;
    logic b0, e0;
    int d0;
    d0 = done_cnt;
    seq_stuck = 1'b1;
    do_scan(0, 0, 1, 0, to, b0, e0);
    seq_stuck = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_err: got %0h expected 1", err); end
    checks++; if (busy !== 1'b0 || to) begin errors++; $display("FAIL to_busy: got %0h expected 0", busy); end
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL to_no_done: got %0d expected %0d", done_cnt, d0); end
    checks++;
    if (run_cyc_q.size() != 1 || err_rise_cyc - run_cyc_q[0] != ACK_TO) begin
      errors++; $display("FAIL to_latency: got %0d expected %0d", (run_cyc_q.size() > 0) ? err_rise_cyc - run_cyc_q[0] : -1, ACK_TO);
    end
    do_scan(3, 3, 1, 0, to, b0, e0);
    checks++; if (e0 !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL to_err_cleared: got %0h expected 0", err); end
    checks++; if (done_cnt - d0 != 1 || to) begin errors++; $display("FAIL to_restart_done: got %0d expected 1", done_cnt - d0); end
  endtask

  task automatic test_abort();
    int d0;
    int n;
    d0 = done_cnt;
    got_q.delete();
    sel_first = 4'd0;
    sel_last = 4'd1;
    reps_per_sel = 10'd2;
    gap_cycles = 16'd2;
    ext_mode = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (got_q.size() < 2 && n < 100) begin step(); n++; end
    repeat (3) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %0h expected 0", busy); end
    checks++; if (seq_sel !== 4'd0 || cur_rep !== 10'd1) begin errors++; $display("FAIL abort_hold: got sel %0h rep %0h expected sel 0 rep 1", seq_sel, cur_rep); end
    repeat (30) step();
    checks++; if (got_q.size() != 2) begin errors++; $display("FAIL abort_runs: got %0d expected 2", got_q.size()); end
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL abort_no_done: got %0d expected %0d", done_cnt, d0); end
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_abort_busy: got %0h expected 0", busy); end
    repeat (20) step();
    checks++; if (got_q.size() != 2) begin errors++; $display("FAIL start_abort_runs: got %0d expected 2", got_q.size()); end
  endtask

  task automatic test_reps_zero();
    bit to;
    logic b0, e0;
    int d0;
    d0 = done_cnt;
    build_exp(5, 5, 0);
    do_scan(5, 5, 0, 3, to, b0, e0);
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL reps0_runs: got %0d expected 1", got_q.size()); end
    checks++; if (got_q.size() > 0 && got_q[0] !== exp_q[0]) begin errors++; $display("FAIL reps0_sel: got %0h expected %0h", got_q[0], exp_q[0]); end
    checks++; if (done_cnt - d0 != 1 || to) begin errors++; $display("FAIL reps0_done: got %0d expected 1", done_cnt - d0); end
  endtask

  task automatic test_reset_mid();
    int n;
    got_q.delete();
    sel_first = 4'd9;
    sel_last = 4'd12;
    reps_per_sel = 10'd2;
    gap_cycles = 16'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (got_q.size() < 1 && n < 50) begin step(); n++; end
    @(negedge clk);
    #2;
    res_n = 1'b0;
    #1;
    checks++;
    if ({seq_run, seq_sel, cur_rep, busy, done, err} !== '0) begin
      errors++; $display("FAIL reset_mid: got %0h expected 0", {seq_run, seq_sel, cur_rep, busy, done, err});
    end
    step();
    res_n = 1'b1;
    repeat (15) step();
  endtask

  task automatic test_random();
    bit to;
    logic b0, e0;
    int d0, f, l, r, g;
    for (int it = 0; it < 4; it++) begin
      f = $urandom_range(0, NSEL - 1);
      l = $urandom_range(0, NSEL - 1);
      r = $urandom_range(0, 3);
      g = $urandom_range(0, 4);
      d0 = done_cnt;
      build_exp(f, l, r);
      do_scan(f, l, r, g, to, b0, e0);
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd%0d_runs: got %0d expected %0d", it, got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd%0d_run%0d: got %0h expected %0h", it, i, got_q[i], exp_q[i]); end
      end
      checks++; if (done_cnt - d0 != 1 || to) begin errors++; $display("FAIL rnd%0d_done: got %0d expected 1", it, done_cnt - d0); end
    end
  endtask

  initial begin
    repeat (3) step();
    test_reset();
    res_n = 1'b1;
    repeat (2) step();
    test_internal();
    test_wrap();
    test_ext();
    test_timeout();
    test_abort();
    test_reps_zero();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
